// File: rtl/muldiv_if.sv
// muldiv_if: EXE-stage controls, operands, multiplier/divider handshake
// and HI/LO results for muldiv_ctrl. master = driver side, slave = muldiv_ctrl.
interface muldiv_if;
  logic        EXE_new;
  logic        EXE_MULT;
  logic        EXE_DIV;
  logic        EXE_MTHI;
  logic        EXE_MTLO;
  logic        EXE_unsigned;
  logic [31:0] vsrc1;
  logic [31:0] vsrc2;
  logic        flush;
  logic [63:0] mul_result;
  logic        div_complete;
  logic [31:0] div_q;
  logic [31:0] div_r;
  logic        div_start;
  logic        div_signed;
  logic        div_abort;
  logic        muldiv_stall;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output EXE_new, EXE_MULT, EXE_DIV, EXE_MTHI, EXE_MTLO,
    output EXE_unsigned, vsrc1, vsrc2, flush,
    output mul_result, div_complete, div_q, div_r,
    input  div_start, div_signed, div_abort,
    input  muldiv_stall, busy, HI, LO
  );

  modport slave (
    input  EXE_new, EXE_MULT, EXE_DIV, EXE_MTHI, EXE_MTLO,
    input  EXE_unsigned, vsrc1, vsrc2, flush,
    input  mul_result, div_complete, div_q, div_r,
    output div_start, div_signed, div_abort,
    output muldiv_stall, busy, HI, LO
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: HI/LO owner sequencing MULT (fixed latency MUL_LAT), DIV
// (div_start/div_complete handshake), MTHI/MTLO; stalls EXE while busy.
// Ports: clk, resetn (sync, active-low), bus (muldiv_if.slave).
// Option: MULDIV_DIVZERO_BYPASS_EN skips the divider when divisor is 0.
module muldiv_ctrl #(
  parameter int MUL_LAT = 2
) (
  input logic    clk,
  input logic    resetn,
  muldiv_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;

  logic [1:0]  state, state_n;
  logic [2:0]  cnt, cnt_n;
  logic [31:0] hi, hi_n;
  logic [31:0] lo, lo_n;
  logic        sgn, sgn_n;

  logic idle, acc;
  logic mul_acc, div_acc, div_go;
  logic mthi_acc, mtlo_acc;
  logic mul_run, div_run;

  assign idle = (state == IDLE);
  assign acc  = resetn & idle & bus.EXE_new & ~bus.flush;

  // decode priority: MULT, DIV, MTHI, MTLO
  assign mul_acc  = acc & bus.EXE_MULT;
  assign div_acc  = acc & ~bus.EXE_MULT & bus.EXE_DIV;
  assign mthi_acc = acc & ~bus.EXE_MULT & ~bus.EXE_DIV
                  & bus.EXE_MTHI;
  assign mtlo_acc = acc & ~bus.EXE_MULT & ~bus.EXE_DIV
                  & ~bus.EXE_MTHI & bus.EXE_MTLO;

`ifdef MULDIV_DIVZERO_BYPASS_EN
  // zero divisor: stall the accept cycle only, never start the divider
  assign div_go = div_acc & (bus.vsrc2 != 32'd0);
`else
  assign div_go = div_acc;
`endif

  assign mul_run = (state == MUL) & (cnt != 3'd0);
  assign div_run = (state == DIV) & ~bus.div_complete;

  assign bus.muldiv_stall = resetn & ~bus.flush
                          & (mul_acc | div_acc | mul_run | div_run);
  assign bus.busy       = resetn & ~idle;
  assign bus.div_start  = div_go;
  assign bus.div_abort  = resetn & bus.flush & (state == DIV);
  assign bus.div_signed = sgn;
  assign bus.HI         = hi;
  assign bus.LO         = lo;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hi_n    = hi;
    lo_n    = lo;
    sgn_n   = sgn;
    if (bus.flush) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (mul_acc) begin
            state_n = MUL;
            cnt_n   = 3'(MUL_LAT - 1);
          end else if (div_go) begin
            state_n = DIV;
            sgn_n   = ~bus.EXE_unsigned;
          end else if (mthi_acc) begin
            hi_n = bus.vsrc1;
          end else if (mtlo_acc) begin
            lo_n = bus.vsrc1;
          end
        end
        MUL: begin
          if (cnt == 3'd0) begin
            hi_n    = bus.mul_result[63:32];
            lo_n    = bus.mul_result[31:0];
            state_n = IDLE;
          end else begin
            cnt_n = cnt - 3'd1;
          end
        end
        DIV: begin
          if (bus.div_complete) begin
            hi_n    = bus.div_r;
            lo_n    = bus.div_q;
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= 3'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
      sgn   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      hi    <= hi_n;
      lo    <= lo_n;
      sgn   <= sgn_n;
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed scoreboard bench for muldiv_ctrl (MUL_LAT=2).
// Define MULDIV_DIVZERO_BYPASS_EN to check the zero-divisor bypass build.
module tb_muldiv_ctrl;

  logic clk;
  logic resetn;
  int   errors;
  int   checks;
  logic [63:0] exp_q[$];
  logic [63:0] e;
  logic [31:0] hi_m, lo_m;

  muldiv_if bus ();

  muldiv_ctrl #(.MUL_LAT(2)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    #3;
  endtask

  task automatic clr();
    bus.EXE_new      = 1'b0;
    bus.EXE_MULT     = 1'b0;
    bus.EXE_DIV      = 1'b0;
    bus.EXE_MTHI     = 1'b0;
    bus.EXE_MTLO     = 1'b0;
    bus.EXE_unsigned = 1'b0;
    bus.flush        = 1'b0;
    bus.div_complete = 1'b0;
  endtask

  task automatic pop_hilo(input string tag);
    checks++;
    assert (exp_q.size() != 0) else begin
      errors++;
      $error("FAIL %s observed=empty expected=entry", tag);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk(tag, {bus.HI, bus.LO}, e);
      hi_m = e[63:32];
      lo_m = e[31:0];
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    errors = 0;
    checks = 0;
    resetn = 1'b0;
    clr();
    bus.vsrc1 = '0;
    bus.vsrc2 = '0;
    bus.mul_result = '0;
    bus.div_q = '0;
    bus.div_r = '0;
    hi_m = '0;
    lo_m = '0;

    // reset, with a request presented while held
    nxt();
    nxt();
    bus.EXE_new  = 1'b1;
    bus.EXE_MULT = 1'b1;
    bus.EXE_DIV  = 1'b1;
    mid();
    chk("rst_stall", 64'(bus.muldiv_stall), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_dstart", 64'(bus.div_start), 64'd0);
    chk("rst_hilo", {bus.HI, bus.LO}, 64'd0);
    chk("rst_dsgn", 64'(bus.div_signed), 64'd0);
    nxt();
    clr();
    resetn = 1'b1;

    // MULT, MUL_LAT=2; EXE_new during MUL ignored
    nxt();
    bus.EXE_new    = 1'b1;
    bus.EXE_MULT   = 1'b1;
    bus.mul_result = 64'h0000_0001_8000_0000;
    exp_q.push_back(64'h0000_0001_8000_0000);
    mid();
    chk("mul_T_stall", 64'(bus.muldiv_stall), 64'd1);
    chk("mul_T_busy", 64'(bus.busy), 64'd0);
    nxt();
    clr();
    bus.EXE_new  = 1'b1;
    bus.EXE_MTHI = 1'b1;
    bus.vsrc1    = 32'h1234_5678;
    mid();
    chk("mul_T1_stall", 64'(bus.muldiv_stall), 64'd1);
    chk("mul_T1_busy", 64'(bus.busy), 64'd1);
    nxt();
    clr();
    mid();
    chk("mul_T2_stall", 64'(bus.muldiv_stall), 64'd0);
    nxt();
    chk("mul_done_busy", 64'(bus.busy), 64'd0);
    pop_hilo("mul_hilo");

    // unsigned DIV 100/7, completes at T+33
    bus.EXE_new      = 1'b1;
    bus.EXE_DIV      = 1'b1;
    bus.EXE_unsigned = 1'b1;
    bus.vsrc1        = 32'd100;
    bus.vsrc2        = 32'd7;
    exp_q.push_back({32'd2, 32'd14});
    mid();
    chk("div_T_start", 64'(bus.div_start), 64'd1);
    chk("div_T_stall", 64'(bus.muldiv_stall), 64'd1);
    for (int i = 1; i <= 32; i++) begin
      nxt();
      clr();
      mid();
      chk("div_wait_stall", 64'(bus.muldiv_stall), 64'd1);
      chk("div_wait_start", 64'(bus.div_start), 64'd0);
      if (i == 1)
        chk("div_unsigned", 64'(bus.div_signed), 64'd0);
    end
    nxt();
    bus.div_complete = 1'b1;
    bus.div_q = 32'd14;
    bus.div_r = 32'd2;
    mid();
    chk("div_done_stall", 64'(bus.muldiv_stall), 64'd0);
    nxt();
    clr();
    chk("div_done_busy", 64'(bus.busy), 64'd0);
    pop_hilo("div_hilo");

    // div_complete in IDLE is ignored
    bus.div_complete = 1'b1;
    bus.div_q = 32'hAAAA_AAAA;
    bus.div_r = 32'h5555_5555;
    nxt();
    clr();
    chk("idle_cmpl_hilo", {bus.HI, bus.LO}, {hi_m, lo_m});

    // signed DIV flushed at T+5
    bus.EXE_new = 1'b1;
    bus.EXE_DIV = 1'b1;
    bus.vsrc1   = 32'hFFFF_FFF7;
    bus.vsrc2   = 32'd3;
    mid();
    chk("fdiv_start", 64'(bus.div_start), 64'd1);
    nxt();
    clr();
    mid();
    chk("fdiv_signed", 64'(bus.div_signed), 64'd1);
    chk("fdiv_noabort", 64'(bus.div_abort), 64'd0);
    nxt();
    nxt();
    nxt();
    nxt();
    bus.flush = 1'b1;
    mid();
    chk("fdiv_abort", 64'(bus.div_abort), 64'd1);
    chk("fdiv_stall", 64'(bus.muldiv_stall), 64'd0);
    nxt();
    clr();
    mid();
    chk("fdiv_idle", 64'(bus.busy), 64'd0);
    chk("fdiv_abort_off", 64'(bus.div_abort), 64'd0);
    bus.div_complete = 1'b1;
    nxt();
    clr();
    chk("fdiv_hilo", {bus.HI, bus.LO}, {hi_m, lo_m});

    // flush wins over MUL completion
    bus.EXE_new  = 1'b1;
    bus.EXE_MULT = 1'b1;
    bus.mul_result = 64'hFEED_0000_CAFE_0000;
    nxt();
    clr();
    nxt();
    bus.flush = 1'b1;
    mid();
    chk("fmul_stall", 64'(bus.muldiv_stall), 64'd0);
    nxt();
    clr();
    chk("fmul_busy", 64'(bus.busy), 64'd0);
    chk("fmul_hilo", {bus.HI, bus.LO}, {hi_m, lo_m});

    // flush wins over accept
    bus.EXE_new  = 1'b1;
    bus.EXE_MULT = 1'b1;
    bus.flush    = 1'b1;
    mid();
    chk("facc_stall", 64'(bus.muldiv_stall), 64'd0);
    nxt();
    clr();
    chk("facc_busy", 64'(bus.busy), 64'd0);

    // MTHI then MTLO back to back
    bus.EXE_new  = 1'b1;
    bus.EXE_MTHI = 1'b1;
    bus.vsrc1    = 32'hDEAD_BEEF;
    exp_q.push_back({32'hDEAD_BEEF, 32'd5});
    mid();
    chk("mthi_stall", 64'(bus.muldiv_stall), 64'd0);
    nxt();
    clr();
    bus.EXE_new  = 1'b1;
    bus.EXE_MTLO = 1'b1;
    bus.vsrc1    = 32'd5;
    mid();
    chk("mtlo_stall", 64'(bus.muldiv_stall), 64'd0);
    chk("mtlo_busy", 64'(bus.busy), 64'd0);
    nxt();
    clr();
    pop_hilo("mtx_hilo");

    // divide by zero
    bus.EXE_new = 1'b1;
    bus.EXE_DIV = 1'b1;
    bus.vsrc1   = 32'd9;
    bus.vsrc2   = 32'd0;
    mid();
    chk("dz_stall", 64'(bus.muldiv_stall), 64'd1);
`ifdef MULDIV_DIVZERO_BYPASS_EN
    chk("dz_start", 64'(bus.div_start), 64'd0);
    nxt();
    clr();
    mid();
    chk("dz_busy", 64'(bus.busy), 64'd0);
    chk("dz_stall_off", 64'(bus.muldiv_stall), 64'd0);
    chk("dz_hilo", {bus.HI, bus.LO}, {hi_m, lo_m});
`else
    chk("dz_start", 64'(bus.div_start), 64'd1);
    exp_q.push_back({32'd9, 32'hFFFF_FFFF});
    nxt();
    clr();
    mid();
    chk("dz_busy", 64'(bus.busy), 64'd1);
    nxt();
    bus.div_complete = 1'b1;
    bus.div_q = 32'hFFFF_FFFF;
    bus.div_r = 32'd9;
    nxt();
    clr();
    pop_hilo("dz_hilo");
`endif

    // reset while MUL counter == 1
    bus.EXE_new  = 1'b1;
    bus.EXE_MULT = 1'b1;
    bus.mul_result = 64'h1111_2222_3333_4444;
    nxt();
    clr();
    resetn = 1'b0;
    mid();
    chk("rmul_stall", 64'(bus.muldiv_stall), 64'd0);
    chk("rmul_busy", 64'(bus.busy), 64'd0);
    nxt();
    resetn = 1'b1;
    hi_m = '0;
    lo_m = '0;
    mid();
    chk("rmul_idle", 64'(bus.busy), 64'd0);
    chk("rmul_stall2", 64'(bus.muldiv_stall), 64'd0);
    chk("rmul_hilo", {bus.HI, bus.LO}, {hi_m, lo_m});
    nxt();
    chk("rmul_hilo2", {bus.HI, bus.LO}, {hi_m, lo_m});
    chk("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have parameter MUL_LAT, default 2, cycles from multiplier launch to `mul_result` valid (legal 1..7).
REQ-002 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port resetn  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port EXE_new  in  1  one-cycle pulse: new instruction entered EXE with valid operands.
REQ-005 SHALL have ports EXE_MULT, EXE_DIV, EXE_MTHI, EXE_MTLO, EXE_unsigned  in  1 each  decoded EXE-stage controls.
REQ-006 SHALL have ports vsrc1, vsrc2  in  32 each  EXE operands (dividend/divisor; MTHI/MTLO source = vsrc1).
REQ-007 SHALL have port flush  in  1  exception/ERET pipeline clear.
REQ-008 SHALL have port mul_result  in  64  multiplier product, {hi,lo}.
REQ-009 SHALL have ports div_complete  in  1, div_q  in  32, div_r  in  32  divider handshake and results.
REQ-010 SHALL have ports div_start  out  1, div_signed  out  1, div_abort  out  1  divider control.
REQ-011 SHALL have ports muldiv_stall  out  1, busy  out  1, HI  out  32, LO  out  32.

Function
REQ-012 SHALL implement FSM states IDLE, MUL, DIV; `busy` = (state != IDLE).
REQ-013 SHALL accept an operation only in IDLE, in cycle T when EXE_new=1 and flush=0; EXE_new in MUL/DIV SHALL be ignored.
REQ-014 MULT accept: state->MUL, 3-bit counter loaded with MUL_LAT-1; counter decrements each MUL cycle.
REQ-015 In MUL with counter==0 (cycle T+MUL_LAT): HI<=mul_result[63:32], LO<=mul_result[31:0] at end of cycle, state->IDLE.
REQ-016 `muldiv_stall` SHALL be combinational: 1 in accept cycle T and in every MUL/DIV cycle not completing; 0 in the completion cycle.
REQ-017 MULT stall SHALL last exactly MUL_LAT cycles (T..T+MUL_LAT-1).
REQ-018 DIV accept: `div_start`=1 combinationally for cycle T only; `div_signed`=~EXE_unsigned, registered at T and held until IDLE; state->DIV.
REQ-019 In DIV, the cycle `div_complete`=1: HI<=div_r, LO<=div_q, state->IDLE; `div_complete` outside DIV SHALL be ignored.
REQ-020 MTHI/MTLO accepted in IDLE (EXE_new, no flush): HI or LO <= vsrc1 at end of T; no stall, state stays IDLE.
REQ-021 flush=1 in any state: state->IDLE at end of cycle, no HI/LO write that cycle, `muldiv_stall`=0 that cycle.
REQ-022 flush in DIV SHALL pulse `div_abort` for that one cycle.
REQ-023 flush SHALL take priority over simultaneous completion or accept.
REQ-024 HI/LO SHALL change only on REQ-015, REQ-019, REQ-020.

Reset
REQ-025 resetn=0 at a clock edge: state=IDLE, counter=0, HI=0, LO=0, div_signed=0.
REQ-026 While resetn=0: muldiv_stall=0, busy=0, div_start=0, div_abort=0.
REQ-027 Reset mid-operation SHALL abandon it without HI/LO update; `div_abort` SHALL NOT be pulsed by reset.

Configuration
REQ-028 Macro MULDIV_DIVZERO_BYPASS_EN defined: DIV accepted with vsrc2==0 SHALL NOT assert div_start or enter DIV.
REQ-029 In that case stall SHALL be 1 in cycle T only, HI/LO unchanged, state stays IDLE.
REQ-030 Macro undefined: divide-by-zero follows REQ-018/019 like any divide.

Verification
REQ-031 MUL_LAT=2, MULT at T, mul_result=64'h0000_0001_8000_0000 -> stall 1 at T,T+1, 0 at T+2; HI=1, LO=32'h8000_0000 after T+2.
REQ-032 DIV vsrc1=100, vsrc2=7, EXE_unsigned=1; div_complete at T+33 with q=14, r=2 -> div_start only at T, div_signed=0, stall T..T+32, HI=2, LO=14.
REQ-033 DIV accepted, flush at T+5 -> div_abort pulse at T+5, IDLE at T+6, HI/LO unchanged; later div_complete ignored.
REQ-034 MTHI vsrc1=32'hDEAD_BEEF then MTLO vsrc1=5 on consecutive EXE_new cycles -> HI=DEADBEEF, LO=5, stall never 1.
REQ-035 With MULDIV_DIVZERO_BYPASS_EN, DIV vsrc2=0 -> no div_start, stall 1 for one cycle, HI/LO unchanged; without macro -> div_start pulse.
REQ-036 resetn=0 during MUL counter=1 -> next cycle IDLE, HI=LO=0, stall=0.
